// File: rtl/instr_enc_pkg.sv
// Shared types, constants and the field encoder for instr_word_encoder.
package instr_enc_pkg;

    typedef enum logic [1:0] {
        KIND_R   = 2'b00,
        KIND_I   = 2'b01,
        KIND_J   = 2'b10,
        KIND_RSV = 2'b11
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // LSB positions of the instruction fields
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_LSB = 0;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_res_t;

    // Build the instruction word and flag whether the command is legal.
    function automatic enc_res_t encode_cmd(
        input kind_e       kind,
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        enc_res_t res;
        res.legal = 1'b0;
        res.word  = '0;
        case (kind)
            KIND_R: begin
                res.legal                  = 1'b1;
                res.word[OP_LSB +: 6]      = OP_RTYPE;
                res.word[RS_LSB +: 5]      = rs;
                res.word[RT_LSB +: 5]      = rt;
                res.word[RD_LSB +: 5]      = rd;
                res.word[SHAMT_LSB +: 5]   = shamt;
                res.word[FUNCT_LSB +: 6]   = funct;
            end
            KIND_I: begin
                res.legal             = !(op == OP_RTYPE || op == OP_J || op == OP_JAL);
                res.word[OP_LSB +: 6] = op;
                res.word[RS_LSB +: 5] = rs;
                res.word[RT_LSB +: 5] = rt;
                res.word[15:0]        = imm;
            end
            KIND_J: begin
                res.legal             = (op == OP_J || op == OP_JAL);
                res.word[OP_LSB +: 6] = op;
                res.word[25:0]        = target;
            end
            default: begin
                res.legal = 1'b0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/instr_word_encoder_if.sv
// Command and instruction-stream bus of instr_word_encoder.
// slave: the encoder side; master: the command source / word consumer side.
interface instr_word_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [5:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport slave (
        input  in_valid, in_kind, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
               in_target, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_kind, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
               in_target, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/instr_fifo.sv
// Circular-buffer FIFO with first-word fall-through head; head reads 0 while empty.
module instr_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_MAX);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr_q];

    // Occupancy next state; simultaneous push and pop cancel out.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Storage array, no reset needed since head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/instr_word_encoder.sv
// MIPS instruction word encoder: registered encode stage feeding an output FIFO.
// Optional per-class emission counters are built when INSTR_ENC_STATS_EN is defined.
module instr_word_encoder
    import instr_enc_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_word_encoder_if.slave  bus,
    output logic                 err,
    output logic [CNT_W-1:0]     err_cnt
`ifdef INSTR_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0]     r_cnt,
    output logic [CNT_W-1:0]     i_cnt,
    output logic [CNT_W-1:0]     j_cnt
`endif
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    enc_res_t         enc;
    logic             accept, push_cmd, bad_cmd, pop;
    logic             enc_valid_q;
    logic [31:0]      enc_word_q;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             fifo_full, fifo_empty;
    logic [31:0]      fifo_head;

    always_comb begin
        enc = encode_cmd(kind_e'(bus.in_kind), bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd,
                         bus.in_shamt, bus.in_funct, bus.in_imm, bus.in_target);
    end

    assign accept   = bus.in_valid && bus.in_ready;
    assign push_cmd = accept && enc.legal;
    assign bad_cmd  = accept && !enc.legal;
    assign pop      = bus.out_valid && bus.out_ready;

    // Occupancy covers the encode stage too, so the FIFO can never overflow.
    assign bus.in_ready  = (occ_q != OCC_MAX) && !fifo_full;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head;
    assign err           = err_q;
    assign err_cnt       = err_cnt_q;

    // Encode stage: capture the legal word, bubble otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_valid_q <= 1'b0;
            enc_word_q  <= '0;
        end else begin
            enc_valid_q <= push_cmd;
            if (push_cmd) enc_word_q <= enc.word;
        end
    end

    // Error pulse and saturating error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= bad_cmd;
            if (bad_cmd && err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    // Total occupancy next state: encode stage plus FIFO contents.
    always_comb begin
        occ_d = occ_q;
        unique case ({push_cmd, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) occ_q <= '0;
        else     occ_q <= occ_d;
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (enc_valid_q),
        .push_data (enc_word_q),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef INSTR_ENC_STATS_EN
    logic [5:0] out_op;
    assign out_op = bus.out_data[OP_LSB +: 6];

    // Per-class emitted word counters, wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
        end else if (pop) begin
            if (out_op == OP_RTYPE)                    r_cnt <= r_cnt + 1'b1;
            else if (out_op == OP_J || out_op == OP_JAL) j_cnt <= j_cnt + 1'b1;
            else                                       i_cnt <= i_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_word_encoder.sv
// Self-checking bench for instr_word_encoder: scoreboard queue plus monitor process.
module tb_instr_word_encoder;
    logic clk = 1'b0;
    logic rst;
    logic err;
    logic [7:0] err_cnt;
`ifdef INSTR_ENC_STATS_EN
    logic [7:0] r_cnt, i_cnt, j_cnt;
`endif

    instr_word_encoder_if bus ();

    instr_word_encoder #(
        .DEPTH (8),
        .CNT_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err     (err),
        .err_cnt (err_cnt)
`ifdef INSTR_ENC_STATS_EN
        ,
        .r_cnt   (r_cnt),
        .i_cnt   (i_cnt),
        .j_cnt   (j_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    int err_due[$];
    int pop_cyc[$];
    int exp_r = 0, exp_i = 0, exp_j = 0, exp_err = 0;
    int n_illegal = 0, err_seen = 0, last_acc = 0;
    bit rand_mode = 0, ready_fixed = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
    endtask

    // Reference: word and legality from the field rules with plain arithmetic.
    function automatic logic [32:0] ref_word(input int unsigned kind, op, rs, rt, rd, sh, fn,
                                             imm, tgt);
        int unsigned w;
        bit ok;
        case (kind)
            0: begin ok = 1; w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11)
                               + sh * (1 << 6) + fn; end
            1: begin ok = (op != 0 && op != 2 && op != 3);
                     w = op * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm; end
            2: begin ok = (op == 2 || op == 3); w = op * (1 << 26) + tgt; end
            default: begin ok = 0; w = 0; end
        endcase
        return {ok, w[31:0]};
    endfunction

    // Offer one command and wait for its handshake; called at posedge+1.
    task automatic issue(input int unsigned kind, op, rs, rt, rd, sh, fn, imm, tgt,
                         input bit has_lit, input logic [31:0] lit);
        logic [32:0] m;
        int budget;
        m = ref_word(kind, op, rs, rt, rd, sh, fn, imm, tgt);
        bus.in_kind   = kind[1:0];
        bus.in_op     = op[5:0];
        bus.in_rs     = rs[4:0];
        bus.in_rt     = rt[4:0];
        bus.in_rd     = rd[4:0];
        bus.in_shamt  = sh[4:0];
        bus.in_funct  = fn[5:0];
        bus.in_imm    = imm[15:0];
        bus.in_target = tgt[25:0];
        bus.in_valid  = 1'b1;
        budget = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            budget++;
            if (budget > 200) begin
                fail("accept_timeout");
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        last_acc = cyc;
        if (m[32]) begin
            exp_q.push_back(has_lit ? lit : m[31:0]);
        end else begin
            err_due.push_back(cyc + 1);
            n_illegal++;
            if (exp_err < 255) exp_err++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // out_ready driver: fixed level or random per cycle.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_mode ? ($urandom_range(0, 1) == 1) : ready_fixed;
        end
    end

    // Monitor: pops the scoreboard on each output handshake, checks stall stability
    // and error pulse timing.
    initial begin
        logic [31:0] w;
        logic [5:0] op;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
                    check("stall_data", bus.out_data, prev_data);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_word");
                    end else begin
                        w = exp_q.pop_front();
                        check("word", bus.out_data, w);
                        op = w[31:26];
                        if (op == 0) exp_r++;
                        else if (op == 2 || op == 3) exp_j++;
                        else exp_i++;
                        pop_cyc.push_back(cyc);
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                if (err) begin
                    err_seen++;
                    if (err_due.size() == 0) fail("unexpected_err");
                    else check("err_time", cyc, err_due.pop_front());
                end
            end
        end
    end

    task automatic check_stats(input string tag);
`ifdef INSTR_ENC_STATS_EN
        check({tag, "_r_cnt"}, {24'b0, r_cnt}, exp_r);
        check({tag, "_i_cnt"}, {24'b0, i_cnt}, exp_i);
        check({tag, "_j_cnt"}, {24'b0, j_cnt}, exp_j);
`else
        if (tag.len() < 0) fail(tag);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int unsigned k, op;
        rst = 1'b1;
        bus.in_valid = 0; bus.in_kind = 0; bus.in_op = 0; bus.in_rs = 0; bus.in_rt = 0;
        bus.in_rd = 0; bus.in_shamt = 0; bus.in_funct = 0; bus.in_imm = 0; bus.in_target = 0;
        idle(3);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check_stats("rst");
        idle(1);

        // R command, latency two cycles
        ready_fixed = 1;
        pop_cyc.delete();
        issue(0, 6'h3f, 1, 2, 3, 0, 6'h20, 0, 0, 1, 32'h0022_1820);
        base = last_acc;
        drain();
        if (pop_cyc.size() < 1) fail("r_no_pop");
        else check("r_latency", pop_cyc[0], base + 2);
        check_stats("r");

        // I then J back to back
        pop_cyc.delete();
        issue(1, 6'h08, 1, 2, 0, 0, 0, 16'h0005, 0, 1, 32'h2022_0005);
        issue(2, 6'h02, 0, 0, 0, 0, 0, 0, 26'h10, 1, 32'h0800_0010);
        drain();
        if (pop_cyc.size() < 2) fail("ij_pops");
        else check("ij_consecutive", pop_cyc[1], pop_cyc[0] + 1);
        check_stats("ij");

        // Backpressure: fill to DEPTH, hold off the ninth command
        ready_fixed = 0;
        idle(1);
        pop_cyc.delete();
        for (int i = 0; i < 8; i++)
            issue(1, 6'h08 + i, i, i + 1, 0, 0, 0, 16'h1000 + i, 0, 0, 32'h0);
        fork
            issue(0, 0, 7, 6, 5, 4, 6'h21, 0, 0, 0, 32'h0);
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
                check("full_no_pop", pop_cyc.size(), 32'd0);
                @(posedge clk);
                #1;
                ready_fixed = 1;
            end
        join
        if (pop_cyc.size() < 1) fail("bp_no_pop");
        else check("bp_ready_rise", last_acc, pop_cyc[0] + 1);
        drain();
        check_stats("bp");

        // Illegal commands: I with op 2, and reserved kind
        base = err_seen;
        issue(1, 2, 1, 1, 0, 0, 0, 16'h1234, 0, 0, 32'h0);
        issue(3, 6'h08, 1, 1, 1, 1, 1, 1, 1, 0, 32'h0);
        idle(3);
        @(negedge clk);
        check("ill_err_pulses", err_seen - base, 32'd2);
        check("ill_err_cnt", {24'b0, err_cnt}, exp_err);
        check("ill_err_cnt_2", {24'b0, err_cnt}, 32'd2);
        check("ill_no_valid", {31'b0, bus.out_valid}, 32'd0);
        idle(1);

        // Reset with five words buffered
        ready_fixed = 0;
        idle(1);
        for (int i = 0; i < 5; i++)
            issue(1, 6'h0d, i, 0, 0, 0, 0, i * 3, 0, 0, 32'h0);
        idle(3);
        @(negedge clk);
        check("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        err_due.delete();
        exp_r = 0; exp_i = 0; exp_j = 0; exp_err = 0;
        idle(1);
        @(negedge clk);
        check("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_ready", {31'b0, bus.in_ready}, 32'd1);
        check("mid_rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check_stats("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_fixed = 1;
        idle(1);
        issue(0, 0, 4, 5, 6, 2, 6'h00, 0, 0, 1, 32'h0085_3080);
        drain();
        check_stats("post_rst");

        // Randomised traffic with random backpressure
        rand_mode = 1;
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 3) k = 0;
            else if (k <= 6) k = 1;
            else if (k <= 8) k = 2;
            else k = 3;
            op = $urandom_range(0, 63);
            if (k == 1 && $urandom_range(0, 7) == 0) op = $urandom_range(2, 3);
            if (k == 2 && $urandom_range(0, 3) != 0) op = $urandom_range(2, 3);
            issue(k, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                  $urandom_range(0, 32'h3ff_ffff), 0, 32'h0);
        end
        rand_mode = 0;
        ready_fixed = 1;
        drain();
        idle(2);
        @(negedge clk);
        check("rand_err_cnt", {24'b0, err_cnt}, exp_err);
        check("rand_empty", {31'b0, bus.out_valid}, 32'd0);
        check_stats("rand");
        idle(1);

        // Saturation of the error counter
        for (int n = 0; n < 260; n++) issue(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        idle(2);
        @(negedge clk);
        check("sat_err_cnt", {24'b0, err_cnt}, exp_err);
        check("sat_err_cnt_ff", {24'b0, err_cnt}, 32'd255);
        check("err_pulse_total", err_seen, n_illegal);
        check("err_due_empty", err_due.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_word_encoder.md
# instr_word_encoder

Assembles 32-bit MIPS instruction words from field-level commands and streams them to a downstream instruction consumer, such as the instruction-class counter, over a valid/ready interface. Commands are validated and encoded in one registered stage, then buffered in a small FIFO. Optional per-class emission counters mirror the downstream R/I/J classification so the two ends can be cross-checked on the LEDs.

## Interface

Parameters:
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CNT_W`, 8: width of the error and statistics counters.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  encoder can accept a command; equals `!full`.
- `in_kind`  in  2  command class: 00 R, 01 I, 10 J, 11 reserved.
- `in_op`  in  6  opcode (I and J); ignored for R.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each  register and shift fields.
- `in_funct`  in  6  function field (R).
- `in_imm`  in  16  immediate (I).
- `in_target`  in  26  jump target (J).
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer takes the word.
- `out_data`  out  32  encoded instruction word.
- `err`  out  1  one-cycle pulse when an illegal command is accepted.
- `err_cnt`  out  CNT_W  count of illegal commands; saturates.
- `r_cnt`, `i_cnt`, `j_cnt`  out  CNT_W each  emitted words per class (only with the stats macro).

## Operation

- A command is accepted when `in_valid && in_ready`.
- Encoding rules:
  - R: `{6'b000000, rs, rt, rd, shamt, funct}`. `in_op` is ignored; the opcode is forced to 0.
  - I: `{op, rs, rt, imm}`. Legal only if op is not 0, 2 or 3.
  - J: `{op, target}`. Legal only if op is 2 or 3.
  - Kind 11, or an illegal opcode for the kind, is an error.
- Error handling: an error command is consumed (the handshake completes), nothing is pushed, `err` pulses, and `err_cnt` increments and saturates at all-ones.
- Encode stage: one register holding the word and a valid bit. This stage feeds the FIFO push.
- FIFO:
  - Circular buffer of `DEPTH` words with read/write pointers that wrap modulo `DEPTH`.
  - Occupancy counter `0..DEPTH`.
  - The count includes a word held in the encode stage, so a word is never dropped.
- Output: `out_data` is the FIFO head (first-word fall-through). `out_valid = !empty`. Words leave in acceptance order.
- Push and pop in the same cycle leave the occupancy unchanged.
- Full: `in_ready` is low when occupancy is `DEPTH`, even if a pop happens in that cycle (no pass-through). It rises the cycle after a pop.
- Empty: `out_data` is don't-care while `out_valid` is low; `out_valid` never rises combinationally from `in_valid`.
- `out_data` and `out_valid` stay stable while `out_valid && !out_ready`.
- Reset (including in the middle of a stream): the FIFO is emptied, pointers are zeroed, the encode stage is invalidated, and all counters are zeroed.

## Timing

- Latency: a command accepted at cycle N appears on `out_data` with `out_valid` at cycle N+2 when the FIFO is empty (encode register, then FIFO write).
- Throughput: one word per cycle when `out_ready` is held high.
- `err` is asserted at cycle N+1 for an illegal command accepted at cycle N.
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `err` = 0, all counters = 0.

## Configuration

- `INSTR_ENC_STATS_EN` defined:
  - `r_cnt`, `i_cnt` and `j_cnt` exist.
  - They increment on each output handshake, classified by `out_data[31:26]`: 0 is R, 2 or 3 is J, anything else is I.
  - They wrap modulo 2^CNT_W.
- `INSTR_ENC_STATS_EN` undefined: these ports and counters are absent. All other behaviour is identical.

## Structure

- Package `instr_enc_pkg` holds:
  - Kind encodings `KIND_R`, `KIND_I`, `KIND_J`.
  - Opcode constants `OP_RTYPE` = 6'h00, `OP_J` = 6'h02, `OP_JAL` = 6'h03.
  - Field bit positions for opcode, rs, rt, rd, shamt and funct.
- One sub-module, `instr_fifo`: parameterised by `DEPTH` and width. Push/pop ports, `full`, `empty`, first-word fall-through head.

## Test plan

- Reset, then idle: `in_ready` = 1, `out_valid` = 0, `err_cnt` = 0, and with stats all class counts = 0.
- R command with rs=1, rt=2, rd=3, shamt=0, funct=0x20 and `out_ready` = 1: `out_data` = 0x00221820 two cycles later. With stats, `r_cnt` = 1.
- I command with op=0x08, rs=1, rt=2, imm=0x0005, then J command with op=2, target=0x10, back-to-back: `out_data` = 0x20220005 followed by 0x08000010 on consecutive cycles. With stats, `i_cnt` = 1 and `j_cnt` = 1.
- Backpressure with `out_ready` = 0: 8 commands are accepted, then `in_ready` drops and a 9th command is held off. After releasing `out_ready`, the 8 words drain in order, `in_ready` rises one cycle after the first pop, and the 9th command is accepted then.
- Illegal commands (I with op=2, and kind 11): each handshake completes, `err` pulses once per command, `err_cnt` = 2, and no `out_valid`.
- Assert `rst` with 5 words buffered: the next cycle shows `out_valid` = 0, `in_ready` = 1 and counters at 0. A subsequent command encodes normally.
